// File: rtl/max_pooling_2x2_stride_2x2_if.sv
// Pixel stream bus between the convolution stage, the 2x2 max-pool and its consumer.
interface max_pooling_2x2_stride_2x2_if;
  logic [31:0] Data_In;
  logic        Valid_In;
  logic [31:0] Data_Out;
  logic        Valid_Out;
  logic        Frame_Done;

  // Upstream/test side: drives pixels, observes pooled results
  modport master (
    output Data_In,
    output Valid_In,
    input  Data_Out,
    input  Valid_Out,
    input  Frame_Done
  );

  // Pooling block side
  modport slave (
    input  Data_In,
    input  Valid_In,
    output Data_Out,
    output Valid_Out,
    output Frame_Done
  );
endinterface

// File: rtl/max_pooling_2x2_stride_2x2.sv
// Streaming 2x2 / stride-2 max-pool over a raster-order FP32 pixel stream.
// A pair register holds the left pixel of each horizontal pair; a half-width
// row buffer holds the top-row pair maxima until the matching bottom row arrives.
module max_pooling_2x2_stride_2x2 #(
  parameter int unsigned IMG_WIDHT  = 30,
  parameter int unsigned IMG_HEIGHT = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  max_pooling_2x2_stride_2x2_if.slave   bus
);

  localparam int unsigned OUT_W = IMG_WIDHT / 2;
  localparam int unsigned OUT_H = IMG_HEIGHT / 2;
  localparam int unsigned COL_W = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam bit ODD_W = (IMG_WIDHT % 2) != 0;
  localparam bit ODD_H = (IMG_HEIGHT % 2) != 0;

  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDHT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_USED_LAST = COL_W'(2 * OUT_W - 1);
  localparam logic [ROW_W-1:0] ROW_USED_LAST = ROW_W'(2 * OUT_H - 1);

  // Map FP32 onto an unsigned key that orders like the real values (-0 < +0)
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  // Larger of two pixels; on a tie the earlier pixel (a) is kept
  function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
    return (order_key(b) > order_key(a)) ? b : a;
  endfunction

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [31:0]      pair;
  logic [31:0]      rowbuf [OUT_W];

  logic [IDX_W-1:0] idx_c;
  logic [31:0]      pair_max_c;
  logic [31:0]      win_max_c;
  logic             col_used_c;
  logic             row_used_c;
  logic             col_last_c;
  logic             row_last_c;
  logic             win_last_c;

  // Window position decode and the two comparator stages
  always_comb begin
    idx_c      = IDX_W'(col >> 1);
    pair_max_c = fp_max(pair, bus.Data_In);
    win_max_c  = fp_max(rowbuf[idx_c], pair_max_c);
    col_used_c = !(ODD_W && (col == COL_LAST));
    row_used_c = !(ODD_H && (row == ROW_LAST));
    col_last_c = (col == COL_LAST);
    row_last_c = (row == ROW_LAST);
    win_last_c = (col == COL_USED_LAST) && (row == ROW_USED_LAST);
  end

  // Raster counters, pair register and registered pooled output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col            <= '0;
      row            <= '0;
      pair           <= '0;
      bus.Data_Out   <= '0;
      bus.Valid_Out  <= 1'b0;
      bus.Frame_Done <= 1'b0;
    end else begin
      bus.Valid_Out  <= 1'b0;
      bus.Frame_Done <= 1'b0;
      if (bus.Valid_In) begin
        if (col_last_c) begin
          col <= '0;
          row <= row_last_c ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (col_used_c && row_used_c) begin
          if (!col[0]) begin
            pair <= bus.Data_In;
          end else if (row[0]) begin
            bus.Data_Out   <= win_max_c;
            bus.Valid_Out  <= 1'b1;
            bus.Frame_Done <= win_last_c;
          end
        end
      end
    end
  end

  // Top-row pair maxima; contents need no reset since every entry is written before it is read
  always_ff @(posedge clk) begin
    if (bus.Valid_In && col_used_c && row_used_c && col[0] && !row[0]) begin
      rowbuf[idx_c] <= pair_max_c;
    end
  end

endmodule

// File: tb/tb_max_pooling_2x2_stride_2x2.sv
// Scoreboard bench for the 2x2 max-pool: a 4x4 instance and a 5x5 instance.
module tb_max_pooling_2x2_stride_2x2;

  typedef struct {
    logic [31:0] data;
    logic        fd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  max_pooling_2x2_stride_2x2_if if4();
  max_pooling_2x2_stride_2x2_if if5();

  max_pooling_2x2_stride_2x2 #(.IMG_WIDHT(4), .IMG_HEIGHT(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  max_pooling_2x2_stride_2x2 #(.IMG_WIDHT(5), .IMG_HEIGHT(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (if5.slave)
  );

  always #5 clk = ~clk;

  exp_t        q4[$];
  exp_t        q5[$];
  logic [31:0] pix [0:24];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          n_out4   = 0;
  int          n_fd4    = 0;
  int          n_out5   = 0;
  int          n_fd5    = 0;
  bit          model_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  // Small signed integer to FP32 bits (|v| <= 255)
  function automatic logic [31:0] fp_of(input int v);
    int n;
    int e;
    logic [31:0] mant;
    n = (v < 0) ? -v : v;
    if (n == 0) return (v < 0) ? 32'h8000_0000 : 32'h0;
    e = 0;
    for (int i = 0; i < 8; i++) if (n >= (1 << i)) e = i;
    mant = 32'(n - (1 << e)) << (23 - e);
    return {(v < 0), 8'(127 + e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  // Reference window max in raster order; a later pixel wins only if strictly larger
  function automatic logic [31:0] win_exp(input int r, input int c, input int w);
    logic [31:0] cand [4];
    logic [31:0] best;
    cand[0] = pix[(r - 1) * w + c - 1];
    cand[1] = pix[(r - 1) * w + c];
    cand[2] = pix[r * w + c - 1];
    cand[3] = pix[r * w + c];
    best = cand[0];
    for (int i = 1; i < 4; i++) if (key(cand[i]) > key(best)) best = cand[i];
    return best;
  endfunction

  task automatic drive_pix(input bit sel, input int r, input int c, input int w, input int h,
                           input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel) begin
      if5.Valid_In = 1'b1;
      if5.Data_In  = d;
    end else begin
      if4.Valid_In = 1'b1;
      if4.Data_In  = d;
    end
    if (model_en && (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2))) begin
      e.data = win_exp(r, c, w);
      e.fd   = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
      e.cyc  = cyc + 1;
      if (sel) q5.push_back(e);
      else     q4.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if4.Valid_In = 1'b0;
      if5.Valid_In = 1'b0;
    end
  endtask

  task automatic drive_frame(input bit sel, input int w, input int h, input bit gaps);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        drive_pix(sel, r, c, w, h, pix[r * w + c]);
        if (gaps) idle(1);
      end
    end
  endtask

  // Output monitor for the 4x4 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if4.Valid_Out) begin
        n_out4++;
        if (if4.Frame_Done) n_fd4++;
        if (q4.size() == 0) begin
          check("dut4_unexpected_out", 64'(if4.Data_Out), 64'hDEAD_0000_0000);
        end else begin
          e = q4.pop_front();
          check("dut4_data", 64'(if4.Data_Out), 64'(e.data));
          check("dut4_frame_done", 64'(if4.Frame_Done), 64'(e.fd));
          check("dut4_latency_cyc", 64'(cyc), 64'(e.cyc));
        end
      end else if (if4.Frame_Done) begin
        check("dut4_fd_without_valid", 64'(if4.Frame_Done), 64'd0);
      end
    end
  end

  // Output monitor for the 5x5 instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if5.Valid_Out) begin
        n_out5++;
        if (if5.Frame_Done) n_fd5++;
        if (q5.size() == 0) begin
          check("dut5_unexpected_out", 64'(if5.Data_Out), 64'hDEAD_0000_0000);
        end else begin
          e = q5.pop_front();
          check("dut5_data", 64'(if5.Data_Out), 64'(e.data));
          check("dut5_frame_done", 64'(if5.Frame_Done), 64'(e.fd));
          check("dut5_latency_cyc", 64'(cyc), 64'(e.cyc));
        end
      end else if (if5.Frame_Done) begin
        check("dut5_fd_without_valid", 64'(if5.Frame_Done), 64'd0);
      end
    end
  end

  initial begin
    if4.Valid_In = 1'b0;
    if4.Data_In  = '0;
    if5.Valid_In = 1'b0;
    if5.Data_In  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_data_out4", 64'(if4.Data_Out), 64'd0);
    check("reset_valid_out4", 64'(if4.Valid_Out), 64'd0);
    check("reset_frame_done4", 64'(if4.Frame_Done), 64'd0);
    check("reset_data_out5", 64'(if5.Data_Out), 64'd0);
    check("reset_valid_out5", 64'(if5.Valid_Out), 64'd0);
    check("reset_frame_done5", 64'(if5.Frame_Done), 64'd0);

    // 1.0..16.0, continuous
    for (int i = 0; i < 16; i++) pix[i] = fp_of(i + 1);
    drive_frame(1'b0, 4, 4, 1'b0);
    idle(2);

    // -1.0..-16.0
    for (int i = 0; i < 16; i++) pix[i] = fp_of(-(i + 1));
    drive_frame(1'b0, 4, 4, 1'b0);
    idle(2);

    // Signed-zero window in the top-left corner
    for (int i = 0; i < 16; i++) pix[i] = fp_of(-(i + 1));
    pix[0] = 32'h0000_0000;
    pix[1] = 32'h8000_0000;
    pix[4] = 32'h8000_0000;
    pix[5] = 32'h8000_0000;
    drive_frame(1'b0, 4, 4, 1'b0);
    idle(2);

    // 5x5, Valid_In toggling; trailing column and row dropped
    for (int i = 0; i < 25; i++) pix[i] = fp_of(i + 1);
    drive_frame(1'b1, 5, 5, 1'b1);
    idle(2);

    // Two random frames back to back
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) pix[i] = rand_fp();
      drive_frame(1'b0, 4, 4, 1'b0);
    end
    idle(2);

    // Reset right as the first window of a partial frame emerges
    for (int i = 0; i < 16; i++) pix[i] = fp_of(i + 1);
    model_en = 1'b0;
    for (int k = 0; k < 6; k++) drive_pix(1'b0, k / 4, k % 4, 4, 4, pix[k]);
    @(posedge clk);
    #1;
    check("pre_rst_valid_out", 64'(if4.Valid_Out), 64'd1);
    if4.Valid_In = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_valid_out", 64'(if4.Valid_Out), 64'd0);
    check("rst_data_out", 64'(if4.Data_Out), 64'd0);
    check("rst_frame_done", 64'(if4.Frame_Done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_en = 1'b1;
    for (int i = 0; i < 16; i++) pix[i] = fp_of(16 - i);
    drive_frame(1'b0, 4, 4, 1'b0);
    idle(2);

    // All-equal pixels
    for (int i = 0; i < 16; i++) pix[i] = 32'h4000_0000;
    drive_frame(1'b0, 4, 4, 1'b0);
    idle(4);

    check("dut4_queue_drained", 64'(q4.size()), 64'd0);
    check("dut5_queue_drained", 64'(q5.size()), 64'd0);
    check("dut4_output_count", 64'(n_out4), 64'd28);
    check("dut4_frame_done_count", 64'(n_fd4), 64'd7);
    check("dut5_output_count", 64'(n_out5), 64'd4);
    check("dut5_frame_done_count", 64'(n_fd5), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
